// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares the single datapath ALU between two requesters. Port 0 is the core
// execute path. Port 1 is the auxiliary address/branch-target unit.
//
// Operation sequence:
//   - One request is accepted at a time. When both ports are valid, the
//     round-robin priority pointer picks the winner.
//   - The opcode and operands are registered and held on the ALU for
//     ALU_LATENCY cycles.
//   - The ALU result and zero flag are captured.
//   - The captured result is returned to the granted port over its
//     valid/ready response channel.
//
// Parameters:
//   DATA_WIDTH   operand/result width
//   OP_WIDTH     ALU opcode width
//   ALU_LATENCY  cycles the operands are held on the ALU (legal 1..15)
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o     request handshake, per port
//   reqN_op_i, reqN_a_i, reqN_b_i   request opcode and operands
//   rspN_valid_o / rspN_ready_i     response handshake, per port
//   rsp_data_o, rsp_zero_o          captured result and zero flag (shared)
//   alu_op_o, alu_a_o, alu_b_o      registered drive to the ALU
//   alu_result_i, alu_zero_i        ALU outputs
//   busy_o                          high while an operation is in flight
//
// Optional feature (macro ALU_ARB_PERF_CNT_EN):
//   Adds grant0_cnt_o, grant1_cnt_o and conflict_cnt_o. These are 16-bit
//   saturating counters of accepts per port and of accepts made while both
//   ports were valid.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  input  logic                  req1_valid_i,
  output logic                  req0_ready_o,
  output logic                  req1_ready_o,
  input  logic [OP_WIDTH-1:0]   req0_op_i,
  input  logic [OP_WIDTH-1:0]   req1_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  output logic                  rsp0_valid_o,
  output logic                  rsp1_valid_o,
  input  logic                  rsp0_ready_i,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_zero_o,
  output logic [OP_WIDTH-1:0]   alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i,
`ifdef ALU_ARB_PERF_CNT_EN
  output logic [15:0]           grant0_cnt_o,
  output logic [15:0]           grant1_cnt_o,
  output logic [15:0]           conflict_cnt_o,
`endif
  output logic                  busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_prio;     // 0: port 0 wins a tie, 1: port 1 wins
  logic                    r_gnt;      // port owning the operation in flight
  logic [CNT_W-1:0]        r_cnt;
  logic [OP_WIDTH-1:0]     r_op;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_zero;
  logic                    w_win;
  logic                    w_accept;
  logic                    w_rsp_hs;

  // Arbitration: a lone valid port wins outright; a tie goes to the pointer.
  always_comb begin
    w_win = r_prio;
    if (req0_valid_i && !req1_valid_i) begin
      w_win = 1'b0;
    end else if (!req0_valid_i && req1_valid_i) begin
      w_win = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept)        w_state_nxt = S_EXEC;
      S_EXEC: if (r_cnt == '0)     w_state_nxt = S_RESP;
      S_RESP: if (w_rsp_hs)        w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic. Ready is offered only to the winner, and only in IDLE.
  // This also means no new request is taken in the response handshake cycle.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    busy_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready_o = req0_valid_i && !w_win;
        req1_ready_o = req1_valid_i &&  w_win;
      end
      S_EXEC: busy_o = 1'b1;
      S_RESP: begin
        busy_o       = 1'b1;
        rsp0_valid_o = !r_gnt;
        rsp1_valid_o =  r_gnt;
      end
      default: ;
    endcase
  end

  assign w_accept = req0_ready_o || req1_ready_o;
  assign w_rsp_hs = (rsp0_valid_o && rsp0_ready_i) || (rsp1_valid_o && rsp1_ready_i);

  // Operand capture, latency countdown, result capture and pointer update.
  // The operand registers are written only on accept, so the ALU inputs
  // keep their last values outside EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= 1'b0;
      r_gnt  <= 1'b0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_data <= '0;
      r_zero <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_gnt <= w_win;
        r_cnt <= CNT_LOAD;
        r_op  <= w_win ? req1_op_i : req0_op_i;
        r_a   <= w_win ? req1_a_i  : req0_a_i;
        r_b   <= w_win ? req1_b_i  : req0_b_i;
      end
      if (r_state == S_EXEC) begin
        if (r_cnt == '0) begin
          r_data <= alu_result_i;
          r_zero <= alu_zero_i;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if (r_state == S_RESP && w_rsp_hs) begin
        r_prio <= ~r_gnt;
      end
    end
  end

  assign alu_op_o   = r_op;
  assign alu_a_o    = r_a;
  assign alu_b_o    = r_b;
  assign rsp_data_o = r_data;
  assign rsp_zero_o = r_zero;

`ifdef ALU_ARB_PERF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_gnt0_cnt;
  logic [15:0] r_gnt1_cnt;
  logic [15:0] r_conf_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt0_cnt <= '0;
      r_gnt1_cnt <= '0;
      r_conf_cnt <= '0;
    end else if (w_accept) begin
      if (w_win) r_gnt1_cnt <= sat_inc16(r_gnt1_cnt);
      else       r_gnt0_cnt <= sat_inc16(r_gnt0_cnt);
      if (req0_valid_i && req1_valid_i) r_conf_cnt <= sat_inc16(r_conf_cnt);
    end
  end

  assign grant0_cnt_o   = r_gnt0_cnt;
  assign grant1_cnt_o   = r_gnt1_cnt;
  assign conflict_cnt_o = r_conf_cnt;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter. It builds two instances:
//   - dut1 uses ALU_LATENCY=1 and covers arbitration, fairness, back-pressure
//     and reset during EXEC.
//   - dut3 uses ALU_LATENCY=3 and covers operand hold and result sample timing.
//
// A behavioural ALU model feeds each instance. Expected responses for dut1
// are queued when a request is driven and compared when a response appears.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
    logic          zero;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // dut1 signals
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [OW-1:0] req0_op, req1_op;
  logic [DW-1:0] req0_a, req1_a, req0_b, req1_b;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic          alu_zero, busy;

  // dut3 signals (port 1 unused)
  logic          t3_req0_valid, t3_req0_ready, t3_req1_ready;
  logic [OW-1:0] t3_req0_op;
  logic [DW-1:0] t3_req0_a, t3_req0_b;
  logic          t3_rsp0_valid, t3_rsp1_valid, t3_rsp0_ready;
  logic [DW-1:0] t3_rsp_data;
  logic          t3_rsp_zero;
  logic [OW-1:0] t3_alu_op;
  logic [DW-1:0] t3_alu_a, t3_alu_b, t3_alu_res;
  logic          t3_alu_zero, t3_busy;
  logic          t3_ovr_en;
  logic [DW-1:0] t3_ovr_val;

`ifdef ALU_ARB_PERF_CNT_EN
  logic [15:0] pc_g0, pc_g1, pc_cf, t3_pc_g0, t3_pc_g1, t3_pc_cf;
`endif

  function automatic logic [DW-1:0] alu_ref(input logic [OW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a ^ b;
      4'b0011: return a | b;
      4'b0100: return a & b;
      4'b0101: return a << b[4:0];
      4'b0110: return a >> b[4:0];
      4'b0111: return a - b;
      4'b1000: return a + 32'd4;
      4'b1111: return b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_res  = alu_ref(alu_op, alu_a, alu_b);
    alu_zero = (alu_res == '0);
  end

  always_comb begin
    t3_alu_res  = t3_ovr_en ? t3_ovr_val : alu_ref(t3_alu_op, t3_alu_a, t3_alu_b);
    t3_alu_zero = (t3_alu_res == '0);
  end

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .ALU_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
    .req0_ready_o(req0_ready), .req1_ready_o(req1_ready),
    .req0_op_i(req0_op), .req1_op_i(req1_op),
    .req0_a_i(req0_a), .req1_a_i(req1_a),
    .req0_b_i(req0_b), .req1_b_i(req1_b),
    .rsp0_valid_o(rsp0_valid), .rsp1_valid_o(rsp1_valid),
    .rsp0_ready_i(rsp0_ready), .rsp1_ready_i(rsp1_ready),
    .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_res), .alu_zero_i(alu_zero),
`ifdef ALU_ARB_PERF_CNT_EN
    .grant0_cnt_o(pc_g0), .grant1_cnt_o(pc_g1), .conflict_cnt_o(pc_cf),
`endif
    .busy_o(busy)
  );

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid_i(t3_req0_valid), .req1_valid_i(1'b0),
    .req0_ready_o(t3_req0_ready), .req1_ready_o(t3_req1_ready),
    .req0_op_i(t3_req0_op), .req1_op_i(4'b0000),
    .req0_a_i(t3_req0_a), .req1_a_i(32'd0),
    .req0_b_i(t3_req0_b), .req1_b_i(32'd0),
    .rsp0_valid_o(t3_rsp0_valid), .rsp1_valid_o(t3_rsp1_valid),
    .rsp0_ready_i(t3_rsp0_ready), .rsp1_ready_i(1'b0),
    .rsp_data_o(t3_rsp_data), .rsp_zero_o(t3_rsp_zero),
    .alu_op_o(t3_alu_op), .alu_a_o(t3_alu_a), .alu_b_o(t3_alu_b),
    .alu_result_i(t3_alu_res), .alu_zero_i(t3_alu_zero),
`ifdef ALU_ARB_PERF_CNT_EN
    .grant0_cnt_o(t3_pc_g0), .grant1_cnt_o(t3_pc_g1), .conflict_cnt_o(t3_pc_cf),
`endif
    .busy_o(t3_busy)
  );

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic p, input logic [OW-1:0] op,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.port = p;
    e.data = alu_ref(op, a, b);
    e.zero = (e.data == '0);
    sb.push_back(e);
  endtask

  // Wait (bounded) for a dut1 response, compare it with the scoreboard head,
  // then complete the handshake.
  task automatic wait_rsp(input string tag);
    int   n;
    exp_t e;
    logic p;
    n = 0;
    while (!rsp0_valid && !rsp1_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_seen"}, rsp0_valid | rsp1_valid, 1);
    if (!(rsp0_valid | rsp1_valid)) return;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_sb: observed=response expected=none", tag);
      return;
    end
    e = sb.pop_front();
    p = rsp1_valid;
    chk({tag, "_port"}, p, e.port);
    chk({tag, "_one_valid"}, rsp0_valid & rsp1_valid, 0);
    chk({tag, "_data"}, rsp_data, e.data);
    chk({tag, "_zero"}, rsp_zero, e.zero);
    if (p) rsp1_ready = 1'b1;
    else   rsp0_ready = 1'b1;
    #1;
    chk({tag, "_no_accept_in_hs"}, req0_ready | req1_ready, 0);
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=time_limit expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_op = '0; req1_op = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 0; rsp1_ready = 0;
    t3_req0_valid = 0; t3_req0_op = '0; t3_req0_a = '0; t3_req0_b = '0;
    t3_rsp0_ready = 0; t3_ovr_en = 0; t3_ovr_val = '0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    reset = 1'b0;
    tick();

    // Single ADD on port 0
    req0_valid = 1; req0_op = 4'b0000; req0_a = 5; req0_b = 7;
    #1;
    chk("add_ready0", req0_ready, 1);
    chk("add_ready1", req1_ready, 0);
    push(0, 4'b0000, 5, 7);
    tick();
    req0_valid = 0; req0_a = 99;
    chk("add_alu_op", alu_op, 0);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 7);
    chk("add_busy", busy, 1);
    chk("add_exec_ready0", req0_ready, 0);
    chk("add_early_rsp", rsp0_valid, 0);
    tick();
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_rsp1_valid", rsp1_valid, 0);
    chk("add_data", rsp_data, 12);
    wait_rsp("add");

    // Simultaneous requests after reset: port 0 first, then port 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1; req0_op = 4'b0001; req0_a = 9; req0_b = 9;
    req1_valid = 1; req1_op = 4'b0011; req1_a = 3; req1_b = 4;
    #1;
    chk("sim_ready0", req0_ready, 1);
    chk("sim_ready1", req1_ready, 0);
    push(0, 4'b0001, 9, 9);
    push(1, 4'b0011, 3, 4);
    tick();
    req0_valid = 0;
    wait_rsp("sim0");
    #1;
    chk("sim_ready1_next", req1_ready, 1);
    tick();
    req1_valid = 0;
    wait_rsp("sim1");

    // Fairness: both ports continuously valid
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1; req0_op = 4'b0000; req0_a = DW'(i * 10); req0_b = 1;
      req1_valid = 1; req1_op = 4'b0001; req1_a = 100; req1_b = DW'(i);
      #1;
      chk("fair_ready0", req0_ready, ((i % 2) == 0));
      chk("fair_ready1", req1_ready, ((i % 2) == 1));
      if ((i % 2) == 0) push(0, req0_op, req0_a, req0_b);
      else              push(1, req1_op, req1_a, req1_b);
      tick();
      wait_rsp("fair");
    end
    req0_valid = 0; req1_valid = 0;

    // Response back-pressure on port 1
    req1_valid = 1; req1_op = 4'b0100; req1_a = 32'h0000F0F0; req1_b = 32'h0000FF00;
    #1;
    chk("bp_ready1", req1_ready, 1);
    push(1, 4'b0100, 32'h0000F0F0, 32'h0000FF00);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_op = 4'b0000; req0_a = 1; req0_b = 2;
    #1;
    chk("bp_exec_ready0", req0_ready, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_data", rsp_data, 32'h0000F000);
      chk("bp_busy", busy, 1);
      chk("bp_ready0", req0_ready, 0);
      req1_a = $urandom;
      tick();
    end
    wait_rsp("bp");
    #1;
    chk("bp_ready0_after", req0_ready, 1);
    push(0, 4'b0000, 1, 2);
    tick();
    req0_valid = 0;
    wait_rsp("bp_next");

    // Reset during EXEC: operation discarded, pointer back on port 0
    req0_valid = 1; req0_op = 4'b0000; req0_a = 4; req0_b = 4;
    #1;
    chk("rx_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    chk("rx_in_exec", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rx_busy", busy, 0);
    chk("rx_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rx_alu_a", alu_a, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rx_no_rsp", {rsp0_valid, rsp1_valid}, 0);
      chk("rx_idle", busy, 0);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rx_prio_ready0", req0_ready, 1);
    chk("rx_prio_ready1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    tick();

    // ALU_LATENCY=3 instance
    t3_req0_valid = 1; t3_req0_op = 4'b0000; t3_req0_a = 10; t3_req0_b = 20;
    #1;
    chk("l3_ready0", t3_req0_ready, 1);
    tick();
    t3_req0_valid = 0; t3_req0_a = 77;
    t3_ovr_en = 1; t3_ovr_val = 32'hDEAD;
    #1;
    chk("l3_e1_alu_a", t3_alu_a, 10);
    chk("l3_e1_alu_b", t3_alu_b, 20);
    chk("l3_e1_rsp", t3_rsp0_valid, 0);
    tick();
    t3_ovr_val = 32'hBEEF;
    #1;
    chk("l3_e2_alu_a", t3_alu_a, 10);
    chk("l3_e2_rsp", t3_rsp0_valid, 0);
    tick();
    t3_ovr_en = 0;
    #1;
    chk("l3_e3_alu_b", t3_alu_b, 20);
    chk("l3_e3_rsp", t3_rsp0_valid, 0);
    chk("l3_e3_busy", t3_busy, 1);
    tick();
    chk("l3_rsp_valid", t3_rsp0_valid, 1);
    chk("l3_rsp1_valid", t3_rsp1_valid, 0);
    chk("l3_data", t3_rsp_data, 30);
    chk("l3_zero", t3_rsp_zero, 0);
    t3_ovr_en = 1; t3_ovr_val = 32'h0;
    #1;
    chk("l3_data_hold", t3_rsp_data, 30);
    t3_rsp0_ready = 1;
    tick();
    t3_rsp0_ready = 0; t3_ovr_en = 0;
    chk("l3_done_busy", t3_busy, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
